// File: rtl/pjon_line_if.sv
// Pad-side conditioner for the single-wire PJON line: synchronised, deglitched receive,
// registered transmit with collision release, and an idle-bus indicator.
module pjon_line_if #(
  parameter int FilterLen       = 3,
  parameter int CollisionCycles = 4,
  parameter int IdleCycles      = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic soc_tx_i,
  input  logic soc_tx_en_i,
  output logic soc_rx_o,
  input  logic pad_rx_i,
  output logic pad_tx_o,
  output logic pad_tx_en_o,
  output logic collision_o,
  input  logic collision_clr_i,
  output logic idle_o
);

  localparam int FW = $clog2(FilterLen + 1);
  localparam int CW = $clog2(CollisionCycles);
  localparam int IW = $clog2(IdleCycles + 1);

  localparam logic [FW-1:0] FMax = FW'(FilterLen - 1);
  localparam logic [CW-1:0] CMax = CW'(CollisionCycles - 1);
  localparam logic [IW-1:0] IMax = IW'(IdleCycles);

  logic          s1, s2;
  logic          rx_q;
  logic [FW-1:0] fcnt;
  logic          tx_q, en_q;
  logic [CW-1:0] ccnt;
  logic          collision_q;
  logic [IW-1:0] icnt;
  logic          mismatch;
  logic          coll_set;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad_rx_i;
      s2 <= s1;
    end
  end

  // A new level must persist for FilterLen consecutive samples before it is accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_q <= 1'b0;
      fcnt <= '0;
    end else if (s2 == rx_q) begin
      fcnt <= '0;
    end else if (fcnt == FMax) begin
      rx_q <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_comb begin
    mismatch = en_q & (s2 ^ tx_q);
    coll_set = mismatch & (ccnt == CMax);
  end

  // Output enable drops on the same edge that raises the collision flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      tx_q <= soc_tx_i;
      en_q <= soc_tx_en_i & ~collision_q & ~coll_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ccnt <= '0;
    end else if (!mismatch) begin
      ccnt <= '0;
    end else if (coll_set) begin
      ccnt <= '0;
    end else begin
      ccnt <= ccnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= coll_set | (collision_q & ~collision_clr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      icnt <= '0;
    end else if (rx_q || en_q) begin
      icnt <= '0;
    end else if (icnt != IMax) begin
      icnt <= icnt + 1'b1;
    end
  end

  assign soc_rx_o    = rx_q;
  assign pad_tx_o    = tx_q;
  assign pad_tx_en_o = en_q;
  assign collision_o = collision_q;
  assign idle_o      = (icnt == IMax);

endmodule
